// File: rtl/arcade_input_mapper.sv
// Player-input front end: ps2 key latches plus joystick words become registered per-player
// control vectors, start buttons and minimum-width coin pulses, with optional per-player autofire.
module arcade_input_mapper #(
   parameter int PLAYERS       = 2,
   parameter int JOY_SHARED    = 0,
   parameter int COIN_PULSE    = 400000,
   parameter int AUTOFIRE_HALF = 2000000
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic [10:0]          ps2_key,
   input  logic [15:0]          joystick_0,
   input  logic [15:0]          joystick_1,
   input  logic [PLAYERS-1:0]   autofire,
   output logic [5*PLAYERS-1:0] ctrl,
   output logic [PLAYERS-1:0]   start,
   output logic [PLAYERS-1:0]   coin
);
   localparam int AW = $clog2(AUTOFIRE_HALF + 1);
   localparam int CW = $clog2(COIN_PULSE + 1);
   localparam logic [AW-1:0] AF_RELOAD   = AW'(AUTOFIRE_HALF - 1);
   localparam logic [CW-1:0] COIN_RELOAD = CW'(COIN_PULSE - 1);
   localparam bit TWO_P = (PLAYERS > 1);

   typedef enum logic {C_IDLE, C_PULSE} coin_st_t;

   logic            tgl_q;
   logic [1:0][4:0] pkey_q, pkey_d;
   logic [1:0]      skey_q, skey_d, ckey_q, ckey_d;
   logic            pressed;
   logic [4:0]      joy_sh;
   logic [1:0][4:0] joy;
   logic [1:0]      start_req, coin_req;
   logic            unused_in;

   assign pressed = ps2_key[9];

   // The extended-prefix bit is deliberately ignored: both forms of a code map to the same key.
   always_comb begin
      pkey_d = pkey_q;
      skey_d = skey_q;
      ckey_d = ckey_q;
      if (ps2_key[10] != tgl_q) begin
         case (ps2_key[7:0])
            8'h75:        pkey_d[0][3] = pressed;
            8'h72:        pkey_d[0][2] = pressed;
            8'h6B:        pkey_d[0][1] = pressed;
            8'h74:        pkey_d[0][0] = pressed;
            8'h29, 8'h14: pkey_d[0][4] = pressed;
            8'h05, 8'h16: skey_d[0]    = pressed;
            8'h06, 8'h1E: if (TWO_P) skey_d[1] = pressed;
            8'h2E:        ckey_d[0]    = pressed;
            8'h36:        ckey_d[1]    = pressed;
            8'h2D:        if (TWO_P) pkey_d[1][3] = pressed;
            8'h2B:        if (TWO_P) pkey_d[1][2] = pressed;
            8'h23:        if (TWO_P) pkey_d[1][1] = pressed;
            8'h34:        if (TWO_P) pkey_d[1][0] = pressed;
            8'h1C:        if (TWO_P) pkey_d[1][4] = pressed;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      tgl_q <= ps2_key[10];
      if (reset) begin
         pkey_q <= '0;
         skey_q <= '0;
         ckey_q <= '0;
      end else begin
         pkey_q <= pkey_d;
         skey_q <= skey_d;
         ckey_q <= ckey_d;
      end
   end

   assign joy_sh = joystick_0[4:0] | joystick_1[4:0];
   assign joy[0] = (JOY_SHARED != 0) ? joy_sh : joystick_0[4:0];
   assign joy[1] = (JOY_SHARED != 0) ? joy_sh : joystick_1[4:0];

   // Single-player cabinets still honour the second coin key, folded into slot 0.
   assign start_req[0] = skey_q[0] | joystick_0[5];
   assign start_req[1] = skey_q[1] | joystick_1[6];
   assign coin_req[0]  = ckey_q[0] | joystick_0[7] | (!TWO_P & ckey_q[1]);
   assign coin_req[1]  = ckey_q[1] | joystick_1[7];

   assign unused_in = ^{joystick_0[15:8], joystick_0[6], joystick_1[15:8], joystick_1[5], ps2_key[8]};

   for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
      logic [4:0]    req;
      logic [3:0]    dir_q;
      logic          fire_q, fire_d, fprev_q, start_q;
      logic [AW-1:0] af_q, af_d;
      coin_st_t      cst_q, cst_d;
      logic [CW-1:0] ccnt_q, ccnt_d;
      logic          cprev_q;

      assign req = pkey_q[p] | joy[p];

      always_comb begin
         fire_d = 1'b0;
         af_d   = '0;
         if (!req[4]) begin
            fire_d = 1'b0;
         end else if (!autofire[p]) begin
            fire_d = 1'b1;
         end else if (!fprev_q) begin
            fire_d = 1'b1;
            af_d   = AF_RELOAD;
         end else if (af_q == '0) begin
            fire_d = ~fire_q;
            af_d   = AF_RELOAD;
         end else begin
            fire_d = fire_q;
            af_d   = af_q - AW'(1);
         end
      end

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            dir_q   <= '0;
            fire_q  <= 1'b0;
            fprev_q <= 1'b0;
            af_q    <= '0;
            start_q <= 1'b0;
         end else begin
            dir_q   <= req[3:0];
            fire_q  <= fire_d;
            fprev_q <= req[4];
            af_q    <= af_d;
            start_q <= start_req[p];
         end
      end

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            cst_q   <= C_IDLE;
            ccnt_q  <= '0;
            cprev_q <= 1'b0;
         end else begin
            cst_q   <= cst_d;
            ccnt_q  <= ccnt_d;
            cprev_q <= coin_req[p];
         end
      end

      // Rising edges that arrive mid-pulse are dropped; a held request never retriggers.
      always_comb begin
         cst_d  = cst_q;
         ccnt_d = ccnt_q;
         case (cst_q)
            C_IDLE: if (coin_req[p] && !cprev_q) begin
               cst_d  = C_PULSE;
               ccnt_d = COIN_RELOAD;
            end
            C_PULSE: if (ccnt_q == '0) cst_d = C_IDLE;
                     else ccnt_d = ccnt_q - CW'(1);
            default: cst_d = C_IDLE;
         endcase
      end

      assign coin[p]          = (cst_q == C_PULSE);
      assign start[p]         = start_q;
      assign ctrl[5*p +: 5]   = {fire_q, dir_q};
   end

endmodule
